// File: rtl/signdet_frame_sched.sv
// Frame scheduler for the gesture-classifier engine: decimates camera frames, runs the
// engine with a timeout guard and hands each result to the decision filter as one strobe.
module signdet_frame_sched #(
  parameter int unsigned FRAME_DIV   = 4,
  parameter int unsigned TIMEOUT_CYC = 60000,
  parameter bit          SKIP_ON_DET = 1'b1,
  parameter logic [4:0]  NOGEST_IDX  = 5'd9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_enable,
  input  logic        i_frame_rdy,
  input  logic        i_det_vld,
  output logic        o_eng_start,
  input  logic        i_eng_done,
  input  logic [4:0]  i_eng_idx,
  input  logic [15:0] i_eng_diff,
  output logic [4:0]  o_max_idx,
  output logic [15:0] o_diff,
  output logic        o_validp,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_drop_cnt,
  output logic [2:0]  o_dbg_state
);

  // Engine handshake: o_eng_start is a one-cycle request; the engine answers with a
  // one-cycle i_eng_done carrying i_eng_idx/i_eng_diff, honoured only while in RUN.
  // The result leaves as a one-cycle o_validp with o_max_idx/o_diff held until the next one.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  div_cnt, div_nxt;
  logic [15:0] timer, timer_nxt;
  logic        valid_frame;
  logic        load_done;
  logic        load_tmo;
  logic        engine_owned;

  assign valid_frame  = i_frame_rdy && !(SKIP_ON_DET && i_det_vld);
  assign engine_owned = (state == S_START) || (state == S_RUN) || (state == S_EMIT);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    timer_nxt = timer;
    load_done = 1'b0;
    load_tmo  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_enable) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        // Disable wins over a frame arriving in the same cycle.
        if (!i_enable) begin
          state_nxt = S_IDLE;
          div_nxt   = '0;
        end else if (valid_frame) begin
          if (div_cnt == DIV_LAST) begin
            div_nxt   = '0;
            state_nxt = S_START;
          end else begin
            div_nxt = div_cnt + 4'd1;
          end
        end
      end
      S_START: begin
        timer_nxt = TMR_LOAD;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // A done landing on the last timer cycle still counts as a real result.
        if (i_eng_done) begin
          load_done = 1'b1;
          state_nxt = S_EMIT;
        end else if (timer == 16'd0) begin
          load_tmo  = 1'b1;
          state_nxt = S_EMIT;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      S_EMIT: begin
        state_nxt = i_enable ? S_ARMED : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      timer      <= '0;
      o_max_idx  <= NOGEST_IDX;
      o_diff     <= '0;
      o_timeout  <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      timer     <= timer_nxt;
      o_timeout <= load_tmo;
      if (load_done) begin
        o_max_idx <= i_eng_idx;
        o_diff    <= i_eng_diff;
      end else if (load_tmo) begin
        o_max_idx <= NOGEST_IDX;
        o_diff    <= 16'd0;
      end
      if (valid_frame && engine_owned && (o_drop_cnt != 8'hFF)) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

  assign o_eng_start = (state == S_START);
  assign o_validp    = (state == S_EMIT);
  assign o_busy      = (state == S_START) || (state == S_RUN);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_signdet_frame_sched.sv
// Randomised scoreboard bench for signdet_frame_sched: a job-level model predicts starts,
// busy windows, drop counts and results; a monitor checks every result strobe.
module tb_signdet_frame_sched;

  localparam int         FRAME_DIV   = 4;
  localparam int         TIMEOUT_CYC = 400;
  localparam logic [4:0] NOGEST      = 5'd9;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_enable;
  logic        i_frame_rdy;
  logic        i_det_vld;
  logic        o_eng_start;
  logic        i_eng_done;
  logic [4:0]  i_eng_idx;
  logic [15:0] i_eng_diff;
  logic [4:0]  o_max_idx;
  logic [15:0] o_diff;
  logic        o_validp;
  logic        o_busy;
  logic        o_timeout;
  logic [7:0]  o_drop_cnt;
  logic [2:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int drops_exp = 0;
  int div_cnt = 0;
  logic [21:0] exp_q[$];  // {timeout, idx, diff}

  signdet_frame_sched #(
    .FRAME_DIV  (FRAME_DIV),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SKIP_ON_DET(1'b1),
    .NOGEST_IDX (NOGEST)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_enable   (i_enable),
    .i_frame_rdy(i_frame_rdy),
    .i_det_vld  (i_det_vld),
    .o_eng_start(o_eng_start),
    .i_eng_done (i_eng_done),
    .i_eng_idx  (i_eng_idx),
    .i_eng_diff (i_eng_diff),
    .o_max_idx  (o_max_idx),
    .o_diff     (o_diff),
    .o_validp   (o_validp),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout),
    .o_drop_cnt (o_drop_cnt),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_drops();
    return (drops_exp > 255) ? 32'd255 : 32'(drops_exp);
  endfunction

  // ---------------- driver tasks ----------------
  // Issue n_valid counted frames while ARMED; every FRAME_DIV-th counted frame must start the engine.
  task automatic feed(input int n_valid, input int gap);
    int got = 0;
    int iter = 0;
    bit f, d, v, exp_start;
    while (got < n_valid) begin
      if (gap > 0) begin
        f = ((iter % gap) == gap - 1);
        d = 1'b0;
      end else begin
        f = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 3) == 0);
        if (iter > 40) begin
          f = 1'b1;
          d = 1'b0;
        end
      end
      v = f && !d;
      i_frame_rdy = f;
      i_det_vld   = d;
      i_eng_done  = (gap == 0) && ($urandom_range(0, 7) == 0);
      i_eng_idx   = 5'($urandom);
      i_eng_diff  = 16'($urandom);
      exp_start   = 1'b0;
      if (v) begin
        got++;
        if (div_cnt == FRAME_DIV - 1) begin
          div_cnt   = 0;
          exp_start = 1'b1;
        end else begin
          div_cnt++;
        end
      end
      step();
      check("eng_start", 32'(o_eng_start), 32'(exp_start));
      iter++;
    end
    i_eng_done = 1'b0;
  endtask

  // Called at the cycle o_eng_start is seen. Offset j from the start: 0 start, result strobe at 'last'.
  task automatic run_engine(input bit tmo, input int dly, input logic [4:0] idx,
                            input logic [15:0] diff, input int frame_pct, input bit flood,
                            input bit drop_enable);
    int last = tmo ? TIMEOUT_CYC + 1 : dly + 1;
    bit f, d;
    if (tmo) exp_q.push_back({1'b1, NOGEST, 16'h0000});
    for (int j = 0; j <= last; j++) begin
      check("busy", 32'(o_busy), 32'(j < last));
      if (j > 0) check("no_extra_start", 32'(o_eng_start), 32'd0);
      f = flood || ($urandom_range(0, 99) < frame_pct);
      d = !flood && ($urandom_range(0, 3) == 0);
      i_frame_rdy = f;
      i_det_vld   = d;
      if (f && !d) drops_exp++;
      i_eng_done = 1'b0;
      i_eng_idx  = 5'($urandom);
      i_eng_diff = 16'($urandom);
      if (!tmo && j == dly) begin
        i_eng_done = 1'b1;
        i_eng_idx  = idx;
        i_eng_diff = diff;
        exp_q.push_back({1'b0, idx, diff});
      end else if (j == 0 || j == last) begin
        i_eng_done = ($urandom_range(0, 1) == 1);
      end
      if (drop_enable && j == 1) i_enable = 1'b0;
      step();
    end
    i_frame_rdy = 1'b0;
    i_det_vld   = 1'b0;
    i_eng_done  = 1'b0;
    check("state_after_emit", 32'(o_dbg_state), 32'(drop_enable ? ST_IDLE : ST_ARMED));
    check("drop_cnt", 32'(o_drop_cnt), sat_drops());
  endtask

  task automatic job(input bit tmo, input int dly, input int frame_pct);
    feed(FRAME_DIV, 0);
    run_engine(tmo, dly, 5'($urandom), 16'($urandom), frame_pct, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [21:0] e;
    logic [4:0]  held_idx;
    logic [15:0] held_diff;
    held_idx  = NOGEST;
    held_diff = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        held_idx  = NOGEST;
        held_diff = '0;
      end else if (o_validp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_validp: got strobe idx 0x%0h diff 0x%0h, expected no strobe (t=%0t)",
                   o_max_idx, o_diff, $time);
        end else begin
          e = exp_q.pop_front();
          check("result_idx", 32'(o_max_idx), 32'(e[20:16]));
          check("result_diff", 32'(o_diff), 32'(e[15:0]));
          check("result_timeout", 32'(o_timeout), 32'(e[21]));
          held_idx  = e[20:16];
          held_diff = e[15:0];
        end
      end else begin
        check("hold_idx", 32'(o_max_idx), 32'(held_idx));
        check("hold_diff", 32'(o_diff), 32'(held_diff));
        check("timeout_without_strobe", 32'(o_timeout), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn      = 1'b0;
    i_enable    = 1'b0;
    i_frame_rdy = 1'b0;
    i_det_vld   = 1'b0;
    i_eng_done  = 1'b0;
    i_eng_idx   = '0;
    i_eng_diff  = '0;
    step();
    step();
    check("rst_eng_start", 32'(o_eng_start), 32'd0);
    check("rst_validp", 32'(o_validp), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_max_idx", 32'(o_max_idx), 32'(NOGEST));
    check("rst_diff", 32'(o_diff), 32'd0);
    check("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    i_frame_rdy = 1'b1;
    step();
    i_frame_rdy = 1'b0;
    check("idle_ignores_frame", 32'(o_drop_cnt), 32'd0);
    check("idle_stays", 32'(o_dbg_state), 32'(ST_IDLE));
    i_enable = 1'b1;
    step();
    check("enable_arms", 32'(o_dbg_state), 32'(ST_ARMED));

    // Frames 10 cycles apart, done 20 cycles after each start: two runs.
    for (int k = 0; k < 2; k++) begin
      feed(FRAME_DIV, 10);
      run_engine(1'b0, 20, 5'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    end

    // Fixed result, then it must hold after the strobe.
    feed(FRAME_DIV, 0);
    run_engine(1'b0, $urandom_range(1, 30), 5'd3, 16'h2A00, 20, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("fixed_hold_idx", 32'(o_max_idx), 32'd3);
    check("fixed_hold_diff", 32'(o_diff), 32'h2A00);

    // No done at all: timeout result.
    job(1'b1, 0, 20);

    // Masked frames while a detection is shown: no starts, no counting.
    for (int k = 0; k < 20; k++) begin
      i_frame_rdy = 1'b1;
      i_det_vld   = 1'b1;
      step();
      check("masked_no_start", 32'(o_eng_start), 32'd0);
    end
    i_frame_rdy = 1'b0;
    i_det_vld   = 1'b0;
    check("masked_drop_cnt", 32'(o_drop_cnt), sat_drops());
    job(1'b0, $urandom_range(1, 40), 20);

    // Done on the last timer cycle beats the timeout; shortest possible run.
    job(1'b0, TIMEOUT_CYC, 5);
    job(1'b0, 1, 30);

    for (int k = 0; k < 12; k++) job(1'b0, $urandom_range(1, 60), 30);

    // Disable part-way through counting clears the divider; disable wins over same-cycle frame.
    feed(2, 0);
    i_frame_rdy = 1'b1;
    i_det_vld   = 1'b0;
    i_enable    = 1'b0;
    step();
    check("abort_to_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    check("abort_no_start", 32'(o_eng_start), 32'd0);
    div_cnt     = 0;
    i_frame_rdy = 1'b0;
    i_enable    = 1'b1;
    step();
    check("rearm", 32'(o_dbg_state), 32'(ST_ARMED));
    job(1'b0, $urandom_range(1, 40), 20);

    // Disable during a run: run completes, then IDLE ignores frames.
    feed(FRAME_DIV, 0);
    run_engine(1'b0, $urandom_range(5, 40), 5'($urandom), 16'($urandom), 30, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      i_frame_rdy = ($urandom_range(0, 1) == 1);
      step();
      check("idle_after_run", 32'(o_dbg_state), 32'(ST_IDLE));
      check("idle_no_start", 32'(o_eng_start), 32'd0);
    end
    i_frame_rdy = 1'b0;
    check("idle_no_drops", 32'(o_drop_cnt), sat_drops());
    i_enable = 1'b1;
    step();
    check("rearm_after_run", 32'(o_dbg_state), 32'(ST_ARMED));

    // Frame flood during a timed-out run: drop counter saturates.
    feed(FRAME_DIV, 0);
    run_engine(1'b1, 0, 5'd0, 16'd0, 100, 1'b1, 1'b0);
    check("drop_saturated", 32'(o_drop_cnt), 32'd255);

    // Reset in the middle of a run.
    feed(FRAME_DIV, 0);
    i_frame_rdy = 1'b0;
    i_det_vld   = 1'b0;
    step();
    step();
    step();
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("rst_mid_drop_cnt", 32'(o_drop_cnt), 32'd0);
    check("rst_mid_max_idx", 32'(o_max_idx), 32'(NOGEST));
    check("rst_mid_diff", 32'(o_diff), 32'd0);
    check("rst_mid_validp", 32'(o_validp), 32'd0);
    drops_exp = 0;
    div_cnt   = 0;
    step();
    step();
    resetn = 1'b1;
    step();
    check("post_reset_armed", 32'(o_dbg_state), 32'(ST_ARMED));
    job(1'b0, $urandom_range(1, 20), 30);

    for (int k = 0; k < 4; k++) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
